max_pooling_fprop1_mul_arbiter: RTL and testbench

//   Shares one 16s x 16s -> 16 signed multiplier among NUM_REQ requesters in the max-pooling fprop datapath.

---
 rtl/max_pooling_fprop1_mul_pkg.sv | 24 ++
 rtl/max_pooling_fprop1_mul_arbiter_if.sv | 41 ++++
 rtl/max_pooling_fprop1_rr_arb.sv | 35 +++
 rtl/max_pooling_fprop1_mul_arbiter.sv | 101 ++++++++++
 tb/tb_max_pooling_fprop1_mul_arbiter.sv | 392 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/max_pooling_fprop1_mul_pkg.sv
// Shared types and defaults for the max-pooling fprop multiplier arbiter.
// Saturating arithmetic is enabled by MAX_POOLING_FPROP1_MUL_SAT_EN.
package max_pooling_fprop1_mul_pkg;

    localparam int NUM_REQ_DEF    = 4;
    localparam int DATA_WIDTH_DEF = 16;
    localparam int ID_WIDTH_DEF   = $clog2(NUM_REQ_DEF);

    typedef logic signed [15:0]       mul_operand_t;
    typedef logic signed [31:0]       mul_product_t;
    typedef logic [ID_WIDTH_DEF-1:0]  req_id_t;

    // Clamp a full 32-bit product into the signed 16-bit range.
    function automatic mul_operand_t sat16(input mul_product_t p);
        if (p > 32'sd32767) begin
            return 16'sh7FFF;
        end else if (p < -32'sd32768) begin
            return 16'sh8000;
        end else begin
            return p[15:0];
        end
    endfunction

endpackage

// File: rtl/max_pooling_fprop1_mul_arbiter_if.sv
// Requester and result bus of the shared multiplier arbiter.
// rsp_sat exists only when MAX_POOLING_FPROP1_MUL_SAT_EN is defined.
interface max_pooling_fprop1_mul_arbiter_if
    import max_pooling_fprop1_mul_pkg::*;
#(
    parameter int NUM_REQ    = NUM_REQ_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ID_WIDTH   = $clog2(NUM_REQ)
);
    // Handshake: a transfer happens on a rising edge where valid && ready.
    // Senders hold payload stable while valid && !ready; ready never waits on
    // a later valid of the same channel. req_ready is at most one-hot.
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_a;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_b;
    logic                          rsp_valid;
    logic                          rsp_ready;
    logic [ID_WIDTH-1:0]           rsp_id;
    logic [DATA_WIDTH-1:0]         rsp_data;
`ifdef MAX_POOLING_FPROP1_MUL_SAT_EN
    logic                          rsp_sat;
`endif

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data
`ifdef MAX_POOLING_FPROP1_MUL_SAT_EN
        , input rsp_sat
`endif
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data
`ifdef MAX_POOLING_FPROP1_MUL_SAT_EN
        , output rsp_sat
`endif
    );

endinterface

// File: rtl/max_pooling_fprop1_rr_arb.sv
// Combinational round-robin grant: first valid requester at or after ptr.
// The pointer register is owned by the parent.
module max_pooling_fprop1_rr_arb #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]  req_valid,
    input  logic [ID_WIDTH-1:0] ptr,
    input  logic                can_accept,
    output logic [NUM_REQ-1:0]  grant,
    output logic [ID_WIDTH-1:0] grant_idx
);

    int                  sum;
    logic [ID_WIDTH-1:0] idx;

    // Walk from the farthest offset back to ptr so the nearest valid wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        sum       = 0;
        idx       = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            sum = int'(ptr) + k;
            if (sum >= NUM_REQ) sum = sum - NUM_REQ;
            idx = ID_WIDTH'(sum);
            if (req_valid[idx]) begin
                grant      = '0;
                grant[idx] = can_accept;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/max_pooling_fprop1_mul_arbiter.sv
// Round-robin sharing of one signed multiplier with a single tagged result register.
// MAX_POOLING_FPROP1_MUL_SAT_EN selects saturation (plus rsp_sat) instead of wrap.
module max_pooling_fprop1_mul_arbiter
    import max_pooling_fprop1_mul_pkg::*;
#(
    parameter int NUM_REQ    = NUM_REQ_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
    input logic                               ap_clk,
    input logic                               ap_rst_n,
    max_pooling_fprop1_mul_arbiter_if.slave   bus
);

    localparam int PW = 2 * DATA_WIDTH;

    logic [ID_WIDTH-1:0]          ptr;
    logic                         rsp_valid_q;
    logic [ID_WIDTH-1:0]          rsp_id_q;
    logic [DATA_WIDTH-1:0]        rsp_data_q;
    logic                         can_accept;
    logic [NUM_REQ-1:0]           grant;
    logic [ID_WIDTH-1:0]          grant_idx;
    logic                         accept;
    logic signed [DATA_WIDTH-1:0] a_sel;
    logic signed [DATA_WIDTH-1:0] b_sel;
    logic signed [PW-1:0]         prod;
    logic [DATA_WIDTH-1:0]        result;
    logic                         result_sat;

    // Holding off grants during reset keeps req_ready low while ap_rst_n=0.
    assign can_accept = ap_rst_n && (!rsp_valid_q || bus.rsp_ready);

    max_pooling_fprop1_rr_arb #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_arb (
        .req_valid  (bus.req_valid),
        .ptr        (ptr),
        .can_accept (can_accept),
        .grant      (grant),
        .grant_idx  (grant_idx)
    );

    assign accept        = |grant;
    assign bus.req_ready = grant;

    assign a_sel = bus.req_a[int'(grant_idx) * DATA_WIDTH +: DATA_WIDTH];
    assign b_sel = bus.req_b[int'(grant_idx) * DATA_WIDTH +: DATA_WIDTH];
    assign prod  = PW'(a_sel) * PW'(b_sel);

`ifdef MAX_POOLING_FPROP1_MUL_SAT_EN
    // The product fits iff its upper half is a pure sign extension of bit DATA_WIDTH-1.
    assign result_sat = (prod[PW-1:DATA_WIDTH-1] != {(DATA_WIDTH+1){1'b0}}) &&
                        (prod[PW-1:DATA_WIDTH-1] != {(DATA_WIDTH+1){1'b1}});
    assign result     = !result_sat    ? prod[DATA_WIDTH-1:0] :
                        prod[PW-1]     ? {1'b1, {(DATA_WIDTH-1){1'b0}}} :
                                         {1'b0, {(DATA_WIDTH-1){1'b1}}};

    logic rsp_sat_q;
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            rsp_sat_q <= 1'b0;
        end else if (accept) begin
            rsp_sat_q <= result_sat;
        end
    end
    assign bus.rsp_sat = rsp_sat_q;
`else
    assign result_sat = 1'b0;
    assign result     = prod[DATA_WIDTH-1:0];
`endif

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            ptr         <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
        end else if (accept) begin
            rsp_valid_q <= 1'b1;
            rsp_id_q    <= grant_idx;
            rsp_data_q  <= result;
            if (grant_idx == ID_WIDTH'(NUM_REQ - 1)) begin
                ptr <= '0;
            end else begin
                ptr <= grant_idx + 1'b1;
            end
        end else if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;

    logic unused_sat;
    assign unused_sat = result_sat;

endmodule

// File: tb/tb_max_pooling_fprop1_mul_arbiter.sv
// Scenario bench for the shared multiplier arbiter, with a negedge scoreboard model.
// Build with MAX_POOLING_FPROP1_MUL_SAT_EN to exercise the saturating variant.
module tb_max_pooling_fprop1_mul_arbiter;

    localparam int NR = 4;
    localparam int DW = 16;
    localparam int IW = 2;
`ifdef MAX_POOLING_FPROP1_MUL_SAT_EN
    localparam int W = 1 + IW + DW;
`else
    localparam int W = IW + DW;
`endif

    logic ap_clk;
    logic ap_rst_n;
    int   checks = 0;
    int   errors = 0;

    logic [W-1:0] exp_q[$];
    logic         m_valid;
    int           m_ptr;

    max_pooling_fprop1_mul_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

    max_pooling_fprop1_mul_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .bus      (bus.slave)
    );

    // ---------------- clock / reset ----------------
    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic logic [W-1:0] model(input int id, input logic signed [DW-1:0] a,
                                           input logic signed [DW-1:0] b);
        logic signed [31:0] p;
        logic [DW-1:0]      d;
        logic               s;
        logic [IW-1:0]      idv;
        p   = a * b;
        idv = id[IW-1:0];
        d   = p[DW-1:0];
        s   = 1'b0;
`ifdef MAX_POOLING_FPROP1_MUL_SAT_EN
        if (p > 32'sd32767) begin
            d = 16'h7FFF; s = 1'b1;
        end else if (p < -32'sd32768) begin
            d = 16'h8000; s = 1'b1;
        end
        return {s, idv, d};
`else
        return {idv, d};
`endif
    endfunction

    function automatic logic [W-1:0] observed();
`ifdef MAX_POOLING_FPROP1_MUL_SAT_EN
        return {bus.rsp_sat, bus.rsp_id, bus.rsp_data};
`else
        return {bus.rsp_id, bus.rsp_data};
`endif
    endfunction

    // ---------------- scoreboard (negedge, inputs are stable here) ----------------
    always @(negedge ap_clk) begin
        logic [NR-1:0] exp_rdy;
        logic [W-1:0]  exp_rsp;
        int            g;
        int            idx;
        exp_rdy = '0;
        g       = -1;
        if (ap_rst_n !== 1'b1) begin
            checks++;
            if (bus.req_ready !== '0) begin
                errors++;
                $display("FAIL sb_ready_in_reset: got %b want 0000", bus.req_ready);
            end
            exp_q.delete();
            m_valid = 1'b0;
            m_ptr   = 0;
        end else begin
            if (!m_valid || bus.rsp_ready) begin
                for (int k = 0; k < NR; k++) begin
                    idx = (m_ptr + k) % NR;
                    if (g < 0 && bus.req_valid[idx]) g = idx;
                end
            end
            if (g >= 0) exp_rdy[g] = 1'b1;
            checks++;
            if (bus.req_ready !== exp_rdy) begin
                errors++;
                $display("FAIL sb_req_ready: got %b want %b", bus.req_ready, exp_rdy);
            end
            checks++;
            if (bus.rsp_valid !== m_valid) begin
                errors++;
                $display("FAIL sb_rsp_valid: got %b want %b", bus.rsp_valid, m_valid);
            end
            if (m_valid && bus.rsp_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected_rsp: got %h want none", observed());
                end else begin
                    exp_rsp = exp_q.pop_front();
                    if (observed() !== exp_rsp) begin
                        errors++;
                        $display("FAIL sb_rsp: got %h want %h", observed(), exp_rsp);
                    end
                end
            end
            if (g >= 0) begin
                exp_q.push_back(model(g, bus.req_a[g*DW +: DW], bus.req_b[g*DW +: DW]));
                m_valid = 1'b1;
                m_ptr   = (g + 1) % NR;
            end else if (bus.rsp_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic set_req(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b);
        bus.req_a[i*DW +: DW] = a;
        bus.req_b[i*DW +: DW] = b;
    endtask

    task automatic randomize_ops();
        for (int i = 0; i < NR; i++) begin
            set_req(i, DW'($urandom_range(0, 65535)), DW'($urandom_range(0, 65535)));
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        ap_rst_n      = 1'b0;
        bus.req_valid = 4'b1111;
        bus.rsp_ready = 1'b1;
        randomize_ops();
        #1;
        checks++;
        if (bus.req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL reset_req_ready: got %b want 0000", bus.req_ready);
        end
        step();
        step();
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.rsp_id !== 2'd0 || bus.rsp_data !== 16'h0000) begin
            errors++;
            $display("FAIL reset_state: got v=%b id=%0d d=%h want 0/0/0000",
                     bus.rsp_valid, bus.rsp_id, bus.rsp_data);
        end
        bus.req_valid = '0;
        ap_rst_n      = 1'b1;
        step();
    endtask

    task automatic test_round_robin();
        logic [NR-1:0] want;
        logic [IW-1:0] want_id;
        randomize_ops();
        bus.req_valid = 4'b1111;
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            want = '0;
            want[k % NR] = 1'b1;
            checks++;
            if (bus.req_ready !== want) begin
                errors++;
                $display("FAIL rr_grant_%0d: got %b want %b", k, bus.req_ready, want);
            end
            step();
            want_id = IW'(k % NR);
            checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== want_id) begin
                errors++;
                $display("FAIL rr_rsp_%0d: got v=%b id=%0d want 1/%0d", k, bus.rsp_valid,
                         bus.rsp_id, want_id);
            end
        end
        bus.req_valid = '0;
        step();
    endtask

    task automatic test_basic();
        set_req(0, 16'd3, -16'sd5);
        bus.req_valid = 4'b0001;
        bus.rsp_ready = 1'b1;
        #1;
        checks++;
        if (bus.req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL basic_ready: got %b want 0001", bus.req_ready);
        end
        step();
        bus.req_valid = '0;
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd0 || bus.rsp_data !== 16'hFFF1) begin
            errors++;
            $display("FAIL basic_rsp: got v=%b id=%0d d=%h want 1/0/fff1",
                     bus.rsp_valid, bus.rsp_id, bus.rsp_data);
        end
        step();
    endtask

    task automatic test_back_pressure();
        logic [DW-1:0] a0;
        logic [DW-1:0] b0;
        logic [W-1:0]  e0;
        randomize_ops();
        a0 = DW'($urandom_range(0, 65535));
        b0 = DW'($urandom_range(0, 65535));
        set_req(0, a0, b0);
        e0 = model(0, a0, b0);
        bus.req_valid = 4'b0001;
        bus.rsp_ready = 1'b0;
        step();
        bus.req_valid = 4'b0110;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (bus.req_ready !== 4'b0000 || bus.rsp_valid !== 1'b1 || observed() !== e0) begin
                errors++;
                $display("FAIL bp_frozen_%0d: got rdy=%b v=%b rsp=%h want 0000/1/%h", k,
                         bus.req_ready, bus.rsp_valid, observed(), e0);
            end
            step();
        end
        bus.rsp_ready = 1'b1;
        #1;
        checks++;
        if (bus.req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL bp_release_req1: got %b want 0010", bus.req_ready);
        end
        step();
        bus.req_valid = 4'b0100;
        #1;
        checks++;
        if (bus.req_ready !== 4'b0100 || bus.rsp_id !== 2'd1) begin
            errors++;
            $display("FAIL bp_release_req2: got rdy=%b id=%0d want 0100/1", bus.req_ready,
                     bus.rsp_id);
        end
        step();
        bus.req_valid = '0;
        checks++;
        if (bus.rsp_id !== 2'd2) begin
            errors++;
            $display("FAIL bp_last_id: got %0d want 2", bus.rsp_id);
        end
        step();
    endtask

    task automatic test_arith();
`ifdef MAX_POOLING_FPROP1_MUL_SAT_EN
        logic [DW-1:0] want_min = 16'h7FFF;
        logic [DW-1:0] want_300 = 16'h7FFF;
`else
        logic [DW-1:0] want_min = 16'h0000;
        logic [DW-1:0] want_300 = 16'h5F90;
`endif
        bus.rsp_ready = 1'b1;
        set_req(0, 16'h8000, 16'h8000);
        bus.req_valid = 4'b0001;
        step();
        checks++;
        if (bus.rsp_data !== want_min) begin
            errors++;
            $display("FAIL arith_min: got %h want %h", bus.rsp_data, want_min);
        end
`ifdef MAX_POOLING_FPROP1_MUL_SAT_EN
        checks++;
        if (bus.rsp_sat !== 1'b1) begin
            errors++;
            $display("FAIL arith_min_sat: got %b want 1", bus.rsp_sat);
        end
`endif
        set_req(0, 16'd300, 16'd300);
        step();
        bus.req_valid = '0;
        checks++;
        if (bus.rsp_data !== want_300) begin
            errors++;
            $display("FAIL arith_300: got %h want %h", bus.rsp_data, want_300);
        end
        step();
    endtask

    task automatic test_reset_inflight();
        randomize_ops();
        bus.req_valid = 4'b0010;
        bus.rsp_ready = 1'b0;
        step();
        ap_rst_n      = 1'b0;
        bus.req_valid = 4'b1001;
        #1;
        checks++;
        if (bus.req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL rst_mid_ready: got %b want 0000", bus.req_ready);
        end
        step();
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.rsp_id !== 2'd0 || bus.rsp_data !== 16'h0000) begin
            errors++;
            $display("FAIL rst_mid_state: got v=%b id=%0d d=%h want 0/0/0000",
                     bus.rsp_valid, bus.rsp_id, bus.rsp_data);
        end
        ap_rst_n      = 1'b1;
        bus.rsp_ready = 1'b1;
        #1;
        checks++;
        if (bus.req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL rst_mid_grant: got %b want 0001", bus.req_ready);
        end
        step();
        bus.req_valid = '0;
        step();
    endtask

    task automatic test_withdraw();
        randomize_ops();
        bus.req_valid = 4'b0010;
        bus.rsp_ready = 1'b0;
        step();
        bus.req_valid = 4'b0100;
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++;
            if (bus.req_ready !== 4'b0000) begin
                errors++;
                $display("FAIL wd_blocked_%0d: got %b want 0000", k, bus.req_ready);
            end
            step();
        end
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        step();
        step();
        checks++;
        if (bus.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL wd_no_rsp: got v=%b id=%0d want v=0", bus.rsp_valid, bus.rsp_id);
        end
        bus.req_valid = 4'b1100;
        #1;
        checks++;
        if (bus.req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL wd_ptr_kept: got %b want 0100", bus.req_ready);
        end
        step();
        bus.req_valid = '0;
        step();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        ap_rst_n      = 1'b0;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b1;
        test_reset();
        test_round_robin();
        test_basic();
        test_back_pressure();
        test_arith();
        test_reset_inflight();
        test_withdraw();
        step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drained: got %0d pending want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
